// File: rtl/fifo_drain_if.sv
// Bus bundle between the ring-buffer drain block, its data-memory port and
// the UART transmitter input.  The drain block is the master of both the
// memory strobes and the TX valid/ready handshake.
interface fifo_drain_if;
   logic        mem_re;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output mem_re, mem_we, mem_addr, mem_wdata, tx_data, tx_valid,
      input  mem_rdata, tx_ready
   );

   modport slave (
      input  mem_re, mem_we, mem_addr, mem_wdata, tx_data, tx_valid,
      output mem_rdata, tx_ready
   );
endinterface

// File: rtl/fifo_drain.sv
// fifo_drain: hardware consumer of the software byte ring buffer.
// Polls the producer write pointer, fetches each pending byte, hands it to the
// UART over valid/ready and then publishes the advanced read pointer so the
// producer can reuse the slot.  Memory has a registered address, so read data
// is consumed in the state after the one that raised mem_re.
module fifo_drain #(
   parameter int unsigned DEPTH     = 10,
   parameter logic [29:0] BUF_BASE  = 30'h1fff0000,
   parameter logic [29:0] WPTR_ADDR = 30'h1fff0015,
   parameter logic [29:0] RPTR_ADDR = 30'h1fff0016
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   fifo_drain_if.master bus,
   output logic [15:0]  bytes_sent,
   output logic         err,
   output logic         busy
);

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_IDLE = 3'd1,
      ST_WPTR = 3'd2,
      ST_DATA = 3'd3,
      ST_SEND = 3'd4,
      ST_WRP  = 3'd5
   } state_t;

   state_t      state_r;
   logic [3:0]  rptr_r;
   logic [7:0]  tx_data_r;
   logic        tx_valid_r;
   logic [15:0] bytes_sent_r;
   logic        err_r;

   logic [3:0]  rptr_next_s;
   logic        wptr_bad_s;
   logic        wptr_empty_s;
   logic        mem_re_s;
   logic        mem_we_s;
   logic [29:0] mem_addr_s;
   logic [31:0] mem_wdata_s;
   logic        busy_s;

   // Ring pointer advance: wraps at the last entry, not at the 4-bit limit.
   function automatic logic [3:0] ptr_advance(input logic [3:0] ptr);
      logic [3:0] nxt;
      if (ptr == 4'(DEPTH - 1)) begin
         nxt = 4'd0;
      end else begin
         nxt = ptr + 4'd1;
      end
      return nxt;
   endfunction

   assign rptr_next_s  = ptr_advance(rptr_r);
   // The whole 32-bit word is range-checked so garbage in the upper bits is caught.
   assign wptr_bad_s   = (bus.mem_rdata >= 32'(DEPTH));
   assign wptr_empty_s = (bus.mem_rdata[3:0] == rptr_r);

   // Control FSM with the registered TX outputs, counters and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_INIT;
         rptr_r       <= 4'd0;
         tx_data_r    <= 8'd0;
         tx_valid_r   <= 1'b0;
         bytes_sent_r <= 16'd0;
         err_r        <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               state_r <= ST_IDLE;
            end
            ST_IDLE: begin
               if (en && !err_r) begin
                  state_r <= ST_WPTR;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WPTR: begin
               if (wptr_bad_s) begin
                  err_r   <= 1'b1;
                  state_r <= ST_IDLE;
               end else if (wptr_empty_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_DATA: begin
               tx_data_r  <= bus.mem_rdata[7:0];
               tx_valid_r <= 1'b1;
               state_r    <= ST_SEND;
            end
            ST_SEND: begin
               if (bus.tx_ready) begin
                  tx_valid_r   <= 1'b0;
                  rptr_r       <= rptr_next_s;
                  bytes_sent_r <= bytes_sent_r + 16'd1;
                  state_r      <= ST_WRP;
               end else begin
                  state_r <= ST_SEND;
               end
            end
            ST_WRP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_INIT;
            end
         endcase
      end
   end

   // Memory strobes, address and write data decoded from state; all quiet in reset.
   always_comb begin
      mem_re_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = 30'd0;
      mem_wdata_s = 32'd0;
      busy_s      = 1'b0;
      if (rst) begin
         busy_s = 1'b0;
      end else begin
         busy_s = (state_r != ST_IDLE);
         case (state_r)
            ST_INIT: begin
               mem_we_s    = 1'b1;
               mem_addr_s  = RPTR_ADDR;
               mem_wdata_s = 32'd0;
            end
            ST_IDLE: begin
               if (en && !err_r) begin
                  mem_re_s   = 1'b1;
                  mem_addr_s = WPTR_ADDR;
               end else begin
                  mem_re_s   = 1'b0;
               end
            end
            ST_WPTR: begin
               if (!wptr_bad_s && !wptr_empty_s) begin
                  mem_re_s   = 1'b1;
                  mem_addr_s = BUF_BASE + {26'd0, rptr_r};
               end else begin
                  mem_re_s   = 1'b0;
               end
            end
            ST_WRP: begin
               // rptr_r was advanced on the handshake edge.
               mem_we_s    = 1'b1;
               mem_addr_s  = RPTR_ADDR;
               mem_wdata_s = {28'd0, rptr_r};
            end
            default: begin
               mem_re_s = 1'b0;
               mem_we_s = 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_re    = mem_re_s;
   assign bus.mem_we    = mem_we_s;
   assign bus.mem_addr  = mem_addr_s;
   assign bus.mem_wdata = mem_wdata_s;
   assign bus.tx_data   = tx_data_r;
   assign bus.tx_valid  = tx_valid_r;
   assign bytes_sent    = bytes_sent_r;
   assign err           = err_r;
   assign busy          = busy_s;

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: a registered-address memory model serves the
// ring buffer and pointers, and each scenario task checks outputs inline
// against hand-computed values, sampling one time unit after the falling edge.
module tb_fifo_drain;
   localparam logic [29:0] BUF_BASE  = 30'h1fff0000;
   localparam logic [29:0] WPTR_ADDR = 30'h1fff0015;
   localparam logic [29:0] RPTR_ADDR = 30'h1fff0016;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] bytes_sent;
   logic        err;
   logic        busy;

   fifo_drain_if bus();

   fifo_drain dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .bus        (bus),
      .bytes_sent (bytes_sent),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Memory model and activity counters
   logic [7:0]  buf_mem [0:9];
   logic [31:0] wptr_word;
   logic [31:0] rptr_word = 32'hffffffff;
   int          n_wptr_rd = 0;
   int          n_buf_rd  = 0;
   int          n_wr      = 0;
   int          n_both    = 0;
   int          n_hs      = 0;
   int          buf_idx;
   logic [29:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];

   int checks = 0;
   int passed = 0;

   always @(posedge clk) begin
      if (bus.mem_re) begin
         if (bus.mem_addr == WPTR_ADDR) begin
            bus.mem_rdata <= wptr_word;
            n_wptr_rd++;
         end else if (bus.mem_addr >= BUF_BASE && bus.mem_addr < BUF_BASE + 30'd10) begin
            buf_idx = int'(bus.mem_addr - BUF_BASE);
            bus.mem_rdata <= {24'd0, buf_mem[buf_idx]};
            n_buf_rd++;
         end else begin
            bus.mem_rdata <= 32'hdeadbeef;
         end
      end
      if (bus.mem_we) begin
         wr_addr_q.push_back(bus.mem_addr);
         wr_data_q.push_back(bus.mem_wdata);
         n_wr++;
         if (bus.mem_addr == RPTR_ADDR) rptr_word <= bus.mem_wdata;
      end
      if (bus.mem_re && bus.mem_we) n_both++;
      if (bus.tx_valid && bus.tx_ready) n_hs++;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      int w0;
      int r0;
      repeat (3) @(posedge clk);
      step();
      checks++; if ({busy, bus.mem_re, bus.mem_we, bus.tx_valid, err} !== 5'b0) $display("FAIL rst_flags: got %b want 00000", {busy, bus.mem_re, bus.mem_we, bus.tx_valid, err}); else passed++;
      checks++; if (bus.mem_addr !== 30'd0 || bus.mem_wdata !== 32'd0) $display("FAIL rst_bus: addr %h wdata %h want 0 0", bus.mem_addr, bus.mem_wdata); else passed++;
      checks++; if (bytes_sent !== 16'd0 || bus.tx_data !== 8'd0) $display("FAIL rst_regs: bytes %h tx_data %h want 0 0", bytes_sent, bus.tx_data); else passed++;
      w0 = n_wr;
      rst = 1'b0;
      #1;
      checks++; if ({bus.mem_we, busy, bus.mem_re} !== 3'b110 || bus.mem_addr !== RPTR_ADDR || bus.mem_wdata !== 32'd0) $display("FAIL init_write: we/busy/re %b addr %h wdata %h want 110 %h 0", {bus.mem_we, busy, bus.mem_re}, bus.mem_addr, bus.mem_wdata, RPTR_ADDR); else passed++;
      step();
      checks++; if (n_wr - w0 !== 1 || wr_addr_q[$] !== RPTR_ADDR || wr_data_q[$] !== 32'd0) $display("FAIL init_log: writes %0d last %h/%h want 1 %h/0", n_wr - w0, wr_addr_q[$], wr_data_q[$], RPTR_ADDR); else passed++;
      checks++; if ({busy, bus.mem_we, bus.mem_re} !== 3'b000) $display("FAIL idle_quiet: busy/we/re %b want 000", {busy, bus.mem_we, bus.mem_re}); else passed++;
      w0 = n_wr;
      r0 = n_wptr_rd + n_buf_rd;
      repeat (10) step();
      checks++; if (n_wr != w0 || n_wptr_rd + n_buf_rd != r0 || bus.tx_valid !== 1'b0 || busy !== 1'b0) $display("FAIL en0_idle: writes %0d reads %0d txv %b busy %b want 0 0 0 0", n_wr - w0, n_wptr_rd + n_buf_rd - r0, bus.tx_valid, busy); else passed++;
   endtask

   task automatic test_empty_poll();
      int r0;
      int b0;
      int w0;
      logic exp_re;
      wptr_word = 32'd0;
      r0 = n_wptr_rd;
      b0 = n_buf_rd;
      w0 = n_wr;
      en = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         exp_re = (i % 2 == 0);
         checks++; if ({bus.mem_re, bus.mem_we, bus.tx_valid} !== {exp_re, 2'b00}) $display("FAIL poll_cyc%0d: re/we/txv %b want %b", i, {bus.mem_re, bus.mem_we, bus.tx_valid}, {exp_re, 2'b00}); else passed++;
         if (exp_re) begin
            checks++; if (bus.mem_addr !== WPTR_ADDR) $display("FAIL poll_addr%0d: got %h want %h", i, bus.mem_addr, WPTR_ADDR); else passed++;
         end
         step();
      end
      en = 1'b0;
      #1;
      checks++; if (n_wptr_rd - r0 != 5 || n_buf_rd != b0 || n_wr != w0) $display("FAIL poll_counts: wptr_rd %0d buf_rd %0d wr %0d want 5 0 0", n_wptr_rd - r0, n_buf_rd - b0, n_wr - w0); else passed++;
   endtask

   task automatic test_single_byte();
      int w0;
      int h0;
      buf_mem[0] = 8'h48;
      wptr_word = 32'd1;
      bus.tx_ready = 1'b1;
      en = 1'b1;
      #1;
      checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== WPTR_ADDR) $display("FAIL sb_c0: re %b addr %h want 1 %h", bus.mem_re, bus.mem_addr, WPTR_ADDR); else passed++;
      step();
      en = 1'b0;
      #1;
      checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== BUF_BASE) $display("FAIL sb_c1: re %b addr %h want 1 %h", bus.mem_re, bus.mem_addr, BUF_BASE); else passed++;
      step();
      checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b1) $display("FAIL sb_c2: txv %b busy %b want 0 1", bus.tx_valid, busy); else passed++;
      step();
      checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h48) $display("FAIL sb_c3: txv %b data %h want 1 48", bus.tx_valid, bus.tx_data); else passed++;
      w0 = n_wr;
      h0 = n_hs;
      step();
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== RPTR_ADDR || bus.mem_wdata !== 32'd1 || bus.tx_valid !== 1'b0) $display("FAIL sb_wrp: we %b addr %h wdata %h txv %b want 1 %h 1 0", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.tx_valid, RPTR_ADDR); else passed++;
      checks++; if (bytes_sent !== 16'd1) $display("FAIL sb_count: got %0d want 1", bytes_sent); else passed++;
      step();
      bus.tx_ready = 1'b0;
      checks++; if (busy !== 1'b0 || n_wr - w0 != 1 || rptr_word !== 32'd1 || n_hs - h0 != 1) $display("FAIL sb_done: busy %b wr %0d rptr %h hs %0d want 0 1 1 1", busy, n_wr - w0, rptr_word, n_hs - h0); else passed++;
   endtask

   task automatic test_wrap_backpressure();
      logic [7:0] exp_b [0:10];
      logic [3:0] exp_w [0:10];
      logic [7:0] init_b;
      logic       stall_ok;
      int         t;
      exp_b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h41, 8'h00};
      exp_w = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
      init_b = 8'h30;
      for (int i = 0; i < 10; i++) buf_mem[i] = init_b + 8'(i);
      wptr_word = 32'd0;
      bus.tx_ready = 1'b0;
      en = 1'b1;
      for (int b = 0; b < 11; b++) begin
         t = 0;
         while (bus.tx_valid !== 1'b1 && t < 30) begin
            step();
            t++;
         end
         checks++; if (bus.tx_valid !== 1'b1) $display("FAIL wrap_wait%0d: tx_valid %b after %0d cycles want 1", b, bus.tx_valid, t); else passed++;
         checks++; if (bus.tx_data !== exp_b[b]) $display("FAIL wrap_byte%0d: got %h want %h", b, bus.tx_data, exp_b[b]); else passed++;
         stall_ok = 1'b1;
         repeat (3) begin
            step();
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_b[b]) stall_ok = 1'b0;
         end
         checks++; if (stall_ok !== 1'b1) $display("FAIL wrap_stall%0d: txv %b data %h want 1 %h held", b, bus.tx_valid, bus.tx_data, exp_b[b]); else passed++;
         bus.tx_ready = 1'b1;
         step();
         bus.tx_ready = 1'b0;
         #1;
         checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== RPTR_ADDR || bus.mem_wdata !== {28'd0, exp_w[b]} || bus.tx_valid !== 1'b0) $display("FAIL wrap_wrp%0d: we %b addr %h wdata %h txv %b want 1 %h %h 0", b, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.tx_valid, RPTR_ADDR, exp_w[b]); else passed++;
         if (b == 8) begin
            buf_mem[0] = 8'h41;
            buf_mem[1] = 8'h00;
            wptr_word = 32'd2;
         end
      end
      en = 1'b0;
      step();
      checks++; if (bytes_sent !== 16'd12 || busy !== 1'b0 || rptr_word !== 32'd2) $display("FAIL wrap_end: bytes %0d busy %b rptr %h want 12 0 2", bytes_sent, busy, rptr_word); else passed++;
   endtask

   task automatic test_bad_pointer();
      int r0;
      int w0;
      int h0;
      wptr_word = 32'h0000000c;
      en = 1'b1;
      #1;
      checks++; if (bus.mem_re !== 1'b1 || bus.mem_addr !== WPTR_ADDR) $display("FAIL bad_poll: re %b addr %h want 1 %h", bus.mem_re, bus.mem_addr, WPTR_ADDR); else passed++;
      step();
      checks++; if ({bus.mem_re, bus.mem_we} !== 2'b00) $display("FAIL bad_wptr: re/we %b want 00", {bus.mem_re, bus.mem_we}); else passed++;
      step();
      checks++; if ({err, busy, bus.mem_re} !== 3'b100) $display("FAIL bad_err: err/busy/re %b want 100", {err, busy, bus.mem_re}); else passed++;
      r0 = n_wptr_rd + n_buf_rd;
      w0 = n_wr;
      h0 = n_hs;
      repeat (10) step();
      checks++; if (n_wptr_rd + n_buf_rd != r0 || n_wr != w0 || n_hs != h0 || bus.tx_valid !== 1'b0) $display("FAIL bad_lock: reads %0d writes %0d hs %0d txv %b want 0 0 0 0", n_wptr_rd + n_buf_rd - r0, n_wr - w0, n_hs - h0, bus.tx_valid); else passed++;
      checks++; if (err !== 1'b1 || bytes_sent !== 16'd12) $display("FAIL bad_hold: err %b bytes %0d want 1 12", err, bytes_sent); else passed++;
      en = 1'b0;
   endtask

   task automatic test_reset_mid_send();
      int t;
      int w0;
      int h0;
      rst = 1'b1;
      step();
      checks++; if (err !== 1'b0 || bytes_sent !== 16'd0) $display("FAIL rs_clear: err %b bytes %0d want 0 0", err, bytes_sent); else passed++;
      rst = 1'b0;
      buf_mem[0] = 8'h5a;
      wptr_word = 32'd1;
      bus.tx_ready = 1'b0;
      step();
      en = 1'b1;
      t = 0;
      while (bus.tx_valid !== 1'b1 && t < 20) begin
         step();
         t++;
      end
      checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5a) $display("FAIL rs_send: txv %b data %h want 1 5a", bus.tx_valid, bus.tx_data); else passed++;
      step();
      h0 = n_hs;
      rst = 1'b1;
      #1;
      checks++; if ({busy, bus.mem_re, bus.mem_we} !== 3'b000 || bus.mem_addr !== 30'd0) $display("FAIL rs_quiet: busy/re/we %b addr %h want 000 0", {busy, bus.mem_re, bus.mem_we}, bus.mem_addr); else passed++;
      step();
      checks++; if (bus.tx_valid !== 1'b0 || bytes_sent !== 16'd0) $display("FAIL rs_drop: txv %b bytes %0d want 0 0", bus.tx_valid, bytes_sent); else passed++;
      w0 = n_wr;
      rst = 1'b0;
      en = 1'b0;
      #1;
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== RPTR_ADDR || bus.mem_wdata !== 32'd0) $display("FAIL rs_init: we %b addr %h wdata %h want 1 %h 0", bus.mem_we, bus.mem_addr, bus.mem_wdata, RPTR_ADDR); else passed++;
      step();
      checks++; if (n_wr - w0 != 1 || wr_data_q[$] !== 32'd0 || n_hs != h0 || busy !== 1'b0) $display("FAIL rs_after: writes %0d data %h hs %0d busy %b want 1 0 0 0", n_wr - w0, wr_data_q[$], n_hs - h0, busy); else passed++;
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      bus.tx_ready = 1'b0;
      wptr_word = 32'd0;
      for (int i = 0; i < 10; i++) buf_mem[i] = 8'd0;
      test_reset();
      test_empty_poll();
      test_single_byte();
      test_wrap_backpressure();
      test_bad_pointer();
      test_reset_mid_send();
      checks++; if (n_both != 0) $display("FAIL re_we_overlap: got %0d cycles want 0", n_both); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
